// File: rtl/pc_fetch_unit_if.sv
// Purpose: fetch-unit bus bundling instruction memory, decoder-select and datapath-return signals.
// Latency: wiring only, no storage.
// Backpressure: imem_ready stalls fetch, exec_done stalls execute; both are driven by the slave side.
interface pc_fetch_unit_if;
    // Instruction memory request / response
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    // Held instruction and PC values, consumed by the decoder and datapath
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    // Next-PC inputs returned by the decoder and datapath
    logic [1:0]  jump_sel;
    logic [1:0]  branch_sel;
    logic        alu_zero;
    logic [31:0] rs_data;
    logic [31:0] mem_rdata;
    logic        exec_done;

    // Sticky misaligned-PC trap
    logic        fault;

    // Fetch unit side
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata,
        output instr,
        output instr_valid,
        output pc,
        output pc_plus4,
        input  jump_sel,
        input  branch_sel,
        input  alu_zero,
        input  rs_data,
        input  mem_rdata,
        input  exec_done,
        output fault
    );

    // Memory / decoder / datapath side
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata,
        input  instr,
        input  instr_valid,
        input  pc,
        input  pc_plus4,
        output jump_sel,
        output branch_sel,
        output alu_zero,
        output rs_data,
        output mem_rdata,
        output exec_done,
        input  fault
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Purpose: program counter and fetch/execute sequencer for the multi-cycle MIPS core.
// Latency: 2 cycles per instruction with zero-wait memory and immediate exec_done.
// Backpressure: each low imem_ready cycle in FETCH and each low exec_done cycle in EXEC adds one cycle.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    pc_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] instr_q;
    logic [31:0] instr_d;

    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic        branch_taken;
    logic [31:0] next_pc;
    logic        next_pc_misaligned;

    // Sequential and PC-relative targets, all modulo 2^32
    assign pc_plus4      = pc_q + 32'd4;
    assign jump_target   = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    assign branch_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign branch_target = pc_plus4 + branch_offset;

    // Branch condition: beq taken on zero, bne taken on non-zero, anything else never taken
    always_comb begin
        branch_taken = 1'b0;
        case (bus.branch_sel)
            2'b01:   branch_taken = bus.alu_zero;
            2'b10:   branch_taken = ~bus.alu_zero;
            default: branch_taken = 1'b0;
        endcase
    end

    // Next-PC select: any jump beats a taken branch, which beats the sequential PC
    always_comb begin
        next_pc = branch_taken ? branch_target : pc_plus4;
        case (bus.jump_sel)
            2'b01:   next_pc = jump_target;
            2'b10:   next_pc = bus.rs_data;
            2'b11:   next_pc = bus.mem_rdata;
            default: next_pc = branch_taken ? branch_target : pc_plus4;
        endcase
    end

    assign next_pc_misaligned = (next_pc[1:0] != 2'b00);

    // State, PC and held instruction; reset aborts any in-flight fetch or execute
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Sequencer: capture instruction on imem_ready, retire on exec_done, trap on misaligned target
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.imem_ready) begin
                    instr_d = bus.imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (bus.exec_done) begin
                    if (next_pc_misaligned) begin
                        // PC is left pointing at the instruction that produced the bad target
                        state_d = ST_FAULT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs decoded straight from the state register so they never glitch mid-cycle
    assign bus.imem_req    = (state_q == ST_FETCH);
    assign bus.instr_valid = (state_q == ST_EXEC);
    assign bus.fault       = (state_q == ST_FAULT);

    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.instr       = instr_q;

endmodule
